// File: rtl/lsm_sequencer.sv
// ARM LDM/STM sequencer: walks the register list, issues one memory transfer per set bit, then base writeback.
// Optional build macro LSM_TIMEOUT_EN adds the MFC timeout counter and the ABORT output.
module lsm_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [31:0] IR,
    input  logic [31:0] BASE,
    input  logic        MFC,
    output logic        BUSY,
    output logic        DONE,
`ifdef LSM_TIMEOUT_EN
    output logic        ABORT,
`endif
    output logic        MEM_REQ,
    output logic        MEM_RW,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  REG_NUM,
    output logic        REG_WE,
    output logic        WB_WE,
    output logic [31:0] WB_VALUE
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_NEXT, S_FIN} state_t;

    state_t      state_q, state_d;
    logic        p_q, u_q, w_q, l_q;
    logic        p_d, u_d, w_d, l_d;
    logic [3:0]  rn_q, rn_d;
    logic [15:0] orig_list_q, orig_list_d;
    logic [15:0] work_q, work_d;
    logic [31:0] base_q, base_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wb_q, wb_d;
    logic [3:0]  reg_num_q, reg_num_d;
    logic [15:0] work_cleared;
    logic [31:0] n4;
    logic        accept;
    logic        timeout_hit;

    logic unused_ir_bits;
    assign unused_ir_bits = &{1'b0, IR[31:28], IR[22]};

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    assign accept       = START && (IR[27:25] == 3'b100);
    assign work_cleared = work_q & ~(16'h0001 << reg_num_q);
    assign n4           = {25'd0, popcount16(orig_list_q), 2'b00};

`ifdef LSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter restarts on every entry into REQ (from SETUP or NEXT).
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_REQ && !MFC) cnt_d = cnt_q + 1'b1;
        else if (state_q != S_REQ)    cnt_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign timeout_hit = (state_q == S_REQ) && !MFC && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SETUP;
            S_SETUP: state_d = (orig_list_q == 16'd0) ? S_FIN : S_REQ;
            S_REQ:   if (MFC) state_d = S_NEXT;
                     else if (timeout_hit) state_d = S_IDLE;
            S_NEXT:  state_d = (work_cleared == 16'd0) ? S_FIN : S_REQ;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        p_d = p_q; u_d = u_q; w_d = w_q; l_d = l_q; rn_d = rn_q;
        orig_list_d = orig_list_q;
        work_d      = work_q;
        base_d      = base_q;
        addr_d      = addr_q;
        wb_d        = wb_q;
        reg_num_d   = reg_num_q;
        case (state_q)
            S_IDLE: if (accept) begin
                p_d = IR[24]; u_d = IR[23]; w_d = IR[21]; l_d = IR[20]; rn_d = IR[19:16];
                orig_list_d = IR[15:0];
                work_d      = IR[15:0];
                base_d      = BASE;
            end
            S_SETUP: begin
                // Every mode walks ascending addresses, so only the start address differs.
                case ({p_q, u_q})
                    2'b01:   addr_d = base_q;
                    2'b11:   addr_d = base_q + 32'd4;
                    2'b00:   addr_d = base_q - n4 + 32'd4;
                    default: addr_d = base_q - n4;
                endcase
                wb_d      = u_q ? (base_q + n4) : (base_q - n4);
                reg_num_d = lowest_set(work_q);
            end
            S_NEXT: begin
                work_d    = work_cleared;
                addr_d    = addr_q + 32'd4;
                reg_num_d = lowest_set(work_cleared);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            p_q <= 1'b0; u_q <= 1'b0; w_q <= 1'b0; l_q <= 1'b0; rn_q <= '0;
            orig_list_q <= '0;
            work_q      <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            wb_q        <= '0;
            reg_num_q   <= '0;
        end else begin
            p_q <= p_d; u_q <= u_d; w_q <= w_d; l_q <= l_d; rn_q <= rn_d;
            orig_list_q <= orig_list_d;
            work_q      <= work_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            wb_q        <= wb_d;
            reg_num_q   <= reg_num_d;
        end
    end

    always_comb begin
        BUSY    = (state_q != S_IDLE);
        DONE    = (state_q == S_FIN);
        MEM_REQ = (state_q == S_REQ);
        MEM_RW  = (state_q == S_REQ) && l_q;
        REG_WE  = (state_q == S_REQ) && l_q && MFC;
        // A loaded base register takes precedence over writeback.
        WB_WE   = (state_q == S_FIN) && w_q && (orig_list_q != 16'd0) && !(l_q && orig_list_q[rn_q]);
`ifdef LSM_TIMEOUT_EN
        ABORT   = timeout_hit;
`endif
    end

    assign MEM_ADDR = addr_q;
    assign REG_NUM  = reg_num_q;
    assign WB_VALUE = wb_q;

endmodule
